// File: rtl/countdown_timer_dec_pkg.sv
// Shared types and BCD limits for the mm:ss countdown timer.
package countdown_timer_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  // Preset digits outside the legal BCD range saturate to the digit's maximum.
  function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] lim);
    return (value > lim) ? lim : value;
  endfunction

endpackage

// File: rtl/countdown_timer_dec_counter.sv
// Loadable BCD 00..59 down counter; one instance for seconds, one for minutes.
module loadable_down_counter_dec_60
  import countdown_timer_dec_pkg::*;
(
  input  logic       clk,
  input  logic       reset_p,
  input  logic       dec_en,
  input  logic       load_enable,
  input  logic [3:0] set_value1,
  input  logic [3:0] set_value10,
  output logic [3:0] dec1,
  output logic [3:0] dec10,
  output logic       borrow_out
);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      dec1  <= 4'd0;
      dec10 <= 4'd0;
    end else if (load_enable) begin
      dec1  <= clamp_digit(set_value1, ONES_MAX);
      dec10 <= clamp_digit(set_value10, TENS_MAX);
    end else if (dec_en) begin
      if (dec1 == 4'd0) begin
        dec1 <= ONES_MAX;
        dec10 <= (dec10 == 4'd0) ? TENS_MAX : dec10 - 4'd1;
      end else begin
        dec1 <= dec1 - 4'd1;
      end
    end
  end

  // Borrow leaves this stage when it wraps 00 -> 59 on a decrement.
  assign borrow_out = dec_en && (dec1 == 4'd0) && (dec10 == 4'd0);

endmodule

// File: rtl/countdown_timer_dec.sv
// Cook-timer countdown: BCD mm:ss chain, run/pause/alarm FSM and alarm hold timer.
module countdown_timer_dec
  import countdown_timer_dec_pkg::*;
#(
  parameter int ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_time,
  input  logic       load_enable,
  input  logic [3:0] set_sec1,
  input  logic [3:0] set_sec10,
  input  logic [3:0] set_min1,
  input  logic [3:0] set_min10,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec1,
  output logic [3:0] sec10,
  output logic [3:0] min1,
  output logic [3:0] min10,
  output logic       running,
  output logic       time_up,
  output logic       alarm
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

  state_t     state;
  logic [7:0] alarm_cnt;

  logic       load_ok;
  logic       cnt_load;
  logic       sec_dec_en;
  logic       sec_borrow;
  logic       min_borrow;
  logic       count_zero;
  logic       terminal;
  logic [3:0] ld_sec1, ld_sec10, ld_min1, ld_min10;

  // A load is ignored while running; clear reuses the load path with zero digits.
  assign load_ok    = load_enable && (state != ST_RUN) && !clear;
  assign cnt_load   = clear || load_ok;
  assign ld_sec1    = clear ? 4'd0 : set_sec1;
  assign ld_sec10   = clear ? 4'd0 : set_sec10;
  assign ld_min1    = clear ? 4'd0 : set_min1;
  assign ld_min10   = clear ? 4'd0 : set_min10;
  assign sec_dec_en = (state == ST_RUN) && clk_time && !clear && !start_stop;

  assign count_zero = (sec1 == 4'd0) && (sec10 == 4'd0) && (min1 == 4'd0) && (min10 == 4'd0);
  assign terminal   = sec_dec_en && (sec1 == 4'd1) && (sec10 == 4'd0) &&
                      (min1 == 4'd0) && (min10 == 4'd0);

  loadable_down_counter_dec_60 u_sec (
    .clk         (clk),
    .reset_p     (reset_p),
    .dec_en      (sec_dec_en),
    .load_enable (cnt_load),
    .set_value1  (ld_sec1),
    .set_value10 (ld_sec10),
    .dec1        (sec1),
    .dec10       (sec10),
    .borrow_out  (sec_borrow)
  );

  loadable_down_counter_dec_60 u_min (
    .clk         (clk),
    .reset_p     (reset_p),
    .dec_en      (sec_borrow),
    .load_enable (cnt_load),
    .set_value1  (ld_min1),
    .set_value10 (ld_min10),
    .dec1        (min1),
    .dec10       (min10),
    .borrow_out  (min_borrow)
  );

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      time_up   <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= 8'd0;
    end else begin
      time_up <= 1'b0;
      if (clear) begin
        state   <= ST_IDLE;
        running <= 1'b0;
        alarm   <= 1'b0;
      end else if (load_ok) begin
        if (state == ST_ALARM) begin
          state <= ST_IDLE;
          alarm <= 1'b0;
        end
      end else if (start_stop) begin
        case (state)
          ST_IDLE, ST_PAUSE: begin
            if (!count_zero) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            alarm <= 1'b0;
          end
        endcase
      end else if (clk_time) begin
        if (state == ST_RUN && terminal) begin
          // Outputs show 00:00, time_up and alarm together on this edge.
          state     <= ST_ALARM;
          running   <= 1'b0;
          time_up   <= 1'b1;
          alarm     <= 1'b1;
          alarm_cnt <= 8'd0;
        end else if (state == ST_ALARM) begin
          if (alarm_cnt == ALARM_LAST) begin
            state <= ST_IDLE;
            alarm <= 1'b0;
          end else begin
            alarm_cnt <= alarm_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_dec.sv
// Directed bench for countdown_timer_dec with hand-computed expected values.
module tb_countdown_timer_dec;

  logic       clk = 1'b0;
  logic       reset_p = 1'b0;
  logic       clk_time = 1'b0;
  logic       load_enable = 1'b0;
  logic [3:0] set_sec1 = 4'd0, set_sec10 = 4'd0, set_min1 = 4'd0, set_min10 = 4'd0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sec1, sec10, min1, min10;
  logic       running, time_up, alarm;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer_dec #(.ALARM_SECS(5)) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .clk_time    (clk_time),
    .load_enable (load_enable),
    .set_sec1    (set_sec1),
    .set_sec10   (set_sec10),
    .set_min1    (set_min1),
    .set_min10   (set_min10),
    .start_stop  (start_stop),
    .clear       (clear),
    .sec1        (sec1),
    .sec10       (sec10),
    .min1        (min1),
    .min10       (min10),
    .running     (running),
    .time_up     (time_up),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] digits();
    return {16'd0, min10, min1, sec10, sec1};
  endfunction

  // One clock with the given pulse inputs held, then outputs are sampled 1ns after the edge.
  task automatic cyc(input logic ss, input logic ld, input logic clr, input logic tk, input logic rst);
    start_stop = ss; load_enable = ld; clear = clr; clk_time = tk; reset_p = rst;
    @(posedge clk); #1;
    start_stop = 0; load_enable = 0; clear = 0; clk_time = 0; reset_p = 0;
  endtask

  task automatic load(input logic [3:0] m10, input logic [3:0] m1, input logic [3:0] s10, input logic [3:0] s1);
    set_min10 = m10; set_min1 = m1; set_sec10 = s10; set_sec1 = s1;
    cyc(0, 1, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check_eq("reset_digits", digits(), 32'h0000);
    check_eq("reset_running", running, 0);
    check_eq("reset_time_up", time_up, 0);
    check_eq("reset_alarm", alarm, 0);

    // 01:05 down across a minute boundary
    load(0, 1, 0, 5);
    check_eq("load_0105", digits(), 32'h0105);
    cyc(1, 0, 0, 0, 0);
    check_eq("start_running", running, 1);
    ticks(5);
    check_eq("t1_0100", digits(), 32'h0100);
    ticks(1);
    check_eq("t1_0059", digits(), 32'h0059);
    check_eq("t1_running", running, 1);

    // Terminal count and alarm hold
    cyc(0, 0, 1, 0, 0);
    check_eq("clear_run_digits", digits(), 32'h0000);
    check_eq("clear_run_running", running, 0);
    load(0, 0, 0, 2);
    cyc(1, 0, 0, 0, 0);
    ticks(1);
    check_eq("t2_0001", digits(), 32'h0001);
    check_eq("t2_no_time_up", time_up, 0);
    ticks(1);
    check_eq("t2_zero", digits(), 32'h0000);
    check_eq("t2_time_up", time_up, 1);
    check_eq("t2_alarm", alarm, 1);
    check_eq("t2_running", running, 0);
    cyc(0, 0, 0, 0, 0);
    check_eq("t2_time_up_pulse", time_up, 0);
    check_eq("t2_alarm_held", alarm, 1);
    ticks(4);
    check_eq("t2_alarm_4ticks", alarm, 1);
    check_eq("t2_alarm_digits", digits(), 32'h0000);
    ticks(1);
    check_eq("t2_alarm_end", alarm, 0);
    cyc(1, 0, 0, 0, 0);
    check_eq("start_at_zero", running, 0);

    // Pause holds; start_stop with tick resumes without decrementing
    load(0, 0, 3, 0);
    cyc(1, 0, 0, 0, 0);
    check_eq("t3_run", running, 1);
    cyc(1, 0, 0, 0, 0);
    check_eq("t3_pause", running, 0);
    ticks(3);
    check_eq("t3_pause_hold", digits(), 32'h0030);
    cyc(1, 0, 0, 1, 0);
    check_eq("t3_resume", running, 1);
    check_eq("t3_resume_hold", digits(), 32'h0030);
    ticks(1);
    check_eq("t3_0029", digits(), 32'h0029);

    // Load during RUN is ignored, tick in the same cycle still counts
    set_min10 = 1; set_min1 = 0; set_sec10 = 0; set_sec1 = 0;
    cyc(0, 1, 0, 1, 0);
    check_eq("t4_load_ignored", digits(), 32'h0028);
    check_eq("t4_still_running", running, 1);

    // Clamped load
    cyc(0, 0, 1, 0, 0);
    load(9, 4, 7, 12);
    check_eq("t5_clamp", digits(), 32'h5459);
    cyc(1, 0, 0, 0, 0);
    ticks(1);
    check_eq("t5_5458", digits(), 32'h5458);

    // Minute borrow 10:00 -> 09:59
    cyc(0, 0, 1, 0, 0);
    load(1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    ticks(1);
    check_eq("borrow_0959", digits(), 32'h0959);

    // Reset mid-run
    cyc(0, 0, 1, 0, 0);
    load(1, 2, 3, 4);
    cyc(1, 0, 0, 0, 0);
    ticks(1);
    check_eq("t6_1233", digits(), 32'h1233);
    cyc(0, 0, 0, 0, 1);
    check_eq("t6_reset_digits", digits(), 32'h0000);
    check_eq("t6_reset_running", running, 0);

    // Clear in ALARM
    load(0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    ticks(1);
    check_eq("t6_alarm_on", alarm, 1);
    cyc(0, 0, 1, 0, 0);
    check_eq("t6_clear_alarm", alarm, 0);
    check_eq("t6_clear_digits", digits(), 32'h0000);
    check_eq("t6_clear_running", running, 0);

    // start_stop acknowledges ALARM; load in ALARM exits to IDLE with new count
    load(0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    ticks(1);
    cyc(1, 0, 0, 0, 0);
    check_eq("ack_alarm", alarm, 0);
    check_eq("ack_running", running, 0);
    load(0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    ticks(1);
    load(0, 2, 0, 0);
    check_eq("alarm_load_alarm", alarm, 0);
    check_eq("alarm_load_digits", digits(), 32'h0200);
    check_eq("alarm_load_idle", running, 0);
    ticks(2);
    check_eq("idle_no_count", digits(), 32'h0200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
